// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared types and sizing for the nibble-serial 16-bit subtractor.
package sub_pkg;

    localparam int W       = 16;
    localparam int NIBBLES = 4;
    localparam int IDX_W   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_subtractor_slice.sv
// Combinational 4-bit subtract slice: s = a + ~b + c_in, rippled through four full adders.
module subtract_slice_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);

    logic [4:0] c;
    logic [3:0] b_n;

    assign c[0] = c_in;
    assign b_n  = ~b;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fa
            assign s[gi]   = a[gi] ^ b_n[gi] ^ c[gi];
            assign c[gi+1] = (a[gi] & b_n[gi]) | (a[gi] & c[gi]) | (b_n[gi] & c[gi]);
        end
    endgenerate

    assign c_out = c[4];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// 16-bit D = A - B - bin computed one nibble per clock through a single 4-bit slice,
// with a Start/Done handshake and a registered result bank.
module nibble_serial_subtractor #(
    parameter int W       = 16,
    parameter int NIBBLES = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         bin,
    output logic [W-1:0] D,
    output logic         bout,
    output logic         Overflow,
    output logic         Zero,
    output logic         Busy,
    output logic         Done
);

    import sub_pkg::*;

    state_t             state_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       acc_q;
    logic [W-1:0]       acc_d;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;

    logic [W-1:0]       d_q;
    logic               bout_q;
    logic               ovf_q;
    logic               zero_q;
    logic               busy_q;
    logic               done_q;

    logic [3:0]         a_nib [NIBBLES];
    logic [3:0]         b_nib [NIBBLES];
    logic [3:0]         a_sel;
    logic [3:0]         b_sel;
    logic [3:0]         slice_s;
    logic               slice_c;

    // Split the latched operands into nibbles and merge the slice result back
    // into the accumulator lane selected by the current index.
    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign a_nib[gi]         = a_q[4*gi +: 4];
            assign b_nib[gi]         = b_q[4*gi +: 4];
            assign acc_d[4*gi +: 4]  = (idx_q == IDX_W'(gi)) ? slice_s : acc_q[4*gi +: 4];
        end
    endgenerate

    assign a_sel = a_nib[idx_q];
    assign b_sel = b_nib[idx_q];

    subtract_slice_4 u_slice (
        .a     (a_sel),
        .b     (b_sel),
        .c_in  (carry_q),
        .s     (slice_s),
        .c_out (slice_c)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (Start) begin
                        a_q     <= A;
                        b_q     <= B;
                        // Subtraction as A + ~B + 1: a borrow-in removes the +1.
                        carry_q <= ~bin;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    acc_q   <= acc_d;
                    carry_q <= slice_c;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == IDX_W'(NIBBLES - 1)) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    d_q     <= acc_q;
                    bout_q  <= ~carry_q;
                    ovf_q   <= (a_q[W-1] != b_q[W-1]) && (acc_q[W-1] != a_q[W-1]);
                    zero_q  <= (acc_q == '0);
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign D        = d_q;
    assign bout     = bout_q;
    assign Overflow = ovf_q;
    assign Zero     = zero_q;
    assign Busy     = busy_q;
    assign Done     = done_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench for nibble_serial_subtractor: directed vectors, random operations
// against an arithmetic reference, back-to-back Start and reset-abort sequences.
module tb_nibble_serial_subtractor;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [15:0] A;
    logic [15:0] B;
    logic        bin;
    logic [15:0] D;
    logic        bout;
    logic        Overflow;
    logic        Zero;
    logic        Busy;
    logic        Done;

    int tests_run = 0;
    int failed    = 0;

    logic [15:0] prev_d;

    nibble_serial_subtractor #(.W(16), .NIBBLES(4)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .A        (A),
        .B        (B),
        .bin      (bin),
        .D        (D),
        .bout     (bout),
        .Overflow (Overflow),
        .Zero     (Zero),
        .Busy     (Busy),
        .Done     (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        bi;
        logic [15:0] d;
        logic        bo;
        logic        ov;
        logic        z;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer subtraction of the operand values.
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic bi,
                                  output logic [15:0] d, output logic bo,
                                  output logic ov, output logic z);
        int diff;
        diff = int'(a) - int'(b) - int'(bi);
        d    = diff[15:0];
        bo   = (diff < 0);
        ov   = (a[15] != b[15]) && (d[15] != a[15]);
        z    = (d == 16'h0000);
    endfunction

    // One full operation: operands and Start are scrambled while the unit is busy,
    // Done latency/pulse width and result hold are checked on the way.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bi,
                          input logic [15:0] ed, input logic eb, input logic eo, input logic ez);
        int done_at;
        int pulses;
        logic held_ok;
        Start = 1'b1; A = a; B = b; bin = bi;
        tick();
        done_at = -1;
        pulses  = 0;
        held_ok = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            A     = 16'($urandom);
            B     = 16'($urandom);
            bin   = 1'($urandom);
            Start = (k <= 5) ? 1'($urandom) : 1'b0;
            tick();
            if (Done) begin
                pulses++;
                if (done_at < 0) done_at = k;
            end
            if (k <= 4 && D !== prev_d) held_ok = 1'b0;
        end
        Start = 1'b0;
        chk("done_latency", done_at, 4);
        chk("done_pulses", pulses, 1);
        chk("d_held_until_done", {31'd0, held_ok}, 32'd1);
        chk("D", {16'd0, D}, {16'd0, ed});
        chk("bout", {31'd0, bout}, {31'd0, eb});
        chk("Overflow", {31'd0, Overflow}, {31'd0, eo});
        chk("Zero", {31'd0, Zero}, {31'd0, ez});
        chk("busy_idle", {31'd0, Busy}, 32'd0);
        $display("[TB] op 0x%04h - 0x%04h - %0d -> D=0x%04h bout=%0d ovf=%0d zero=%0d (exp D=0x%04h)",
                 a, b, bi, D, bout, Overflow, Zero, ed);
        prev_d = ed;
    endtask

    initial begin
        logic [15:0] ra, rb, md;
        logic        rbi, mb, mo, mz;
        int          pos [$];

        vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};

        Reset = 1'b1; Start = 1'b0; A = '0; B = '0; bin = 1'b0;
        prev_d = 16'h0000;
        tick(); tick();
        Reset = 1'b0;
        tick();
        chk("reset_D", {16'd0, D}, 32'd0);
        chk("reset_flags", {26'd0, bout, Overflow, Zero, Busy, Done}, 32'd0);
        $display("[TB] reset: D=0x%04h busy=%0d done=%0d", D, Busy, Done);

        for (int i = 0; i < 6; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].bi, vecs[i].d, vecs[i].bo, vecs[i].ov, vecs[i].z);

        for (int i = 0; i < 30; i++) begin
            ra  = 16'($urandom);
            rb  = (i % 5 == 0) ? ra : 16'($urandom);
            rbi = 1'($urandom);
            model(ra, rb, rbi, md, mb, mo, mz);
            run_op(ra, rb, rbi, md, mb, mo, mz);
        end

        // Start held high: one operation every 6 cycles.
        A = 16'h0100; B = 16'h0001; bin = 1'b0; Start = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (Done) pos.push_back(k);
        end
        Start = 1'b0;
        chk("held_done_count", pos.size(), 3);
        if (pos.size() == 3) begin
            chk("held_done_pos0", pos[0], 5);
            chk("held_done_pos1", pos[1], 11);
            chk("held_done_pos2", pos[2], 17);
        end
        tick(); tick();
        chk("held_D", {16'd0, D}, 32'h00FF);
        $display("[TB] held start: %0d Done pulses, D=0x%04h", pos.size(), D);
        tick(); tick(); tick(); tick();
        prev_d = 16'h00FF;

        // Reset during the second CALC cycle aborts with no Done.
        Start = 1'b1; A = 16'h1234; B = 16'h1111; bin = 1'b0;
        tick();
        Start = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("abort_D", {16'd0, D}, 32'd0);
        chk("abort_flags", {26'd0, bout, Overflow, Zero, Busy, Done}, 32'd0);
        begin
            int late_done;
            late_done = 0;
            for (int k = 0; k < 6; k++) begin
                tick();
                if (Done || Busy) late_done++;
            end
            chk("abort_no_done", late_done, 0);
        end
        $display("[TB] reset mid-op: D=0x%04h busy=%0d done=%0d", D, Busy, Done);
        prev_d = 16'h0000;
        run_op(16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0);

        // Reset and Start together: Reset wins.
        Reset = 1'b1; Start = 1'b1; A = 16'h0003; B = 16'h0001;
        tick();
        Reset = 1'b0; Start = 1'b0;
        tick();
        chk("reset_beats_start", {30'd0, Busy, Done}, 32'd0);
        chk("reset_beats_start_D", {16'd0, D}, 32'd0);
        $display("[TB] reset+start: busy=%0d D=0x%04h", Busy, D);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/nibble_serial_subtractor.md
# nibble_serial_subtractor

- Multi-cycle 16-bit subtractor computing D = A − B − bin.
- Uses a single 4-bit subtract slice, one nibble per clock, LSB nibble first, with the borrow held in a register between nibbles.
- Sits beside the 16-bit adders in the datapath where area matters more than latency. It is the inverse operation to the 16-bit add, behind a Start/Done handshake.

## Interface
Parameters:
- W, 16, operand width; fixed, must equal NIBBLES*4
- NIBBLES, 4, slice iterations per operation

Ports:
- Clk  in  1  single clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high; clears all state and outputs
- Start  in  1  request; sampled only in IDLE
- A  in  16  minuend; captured on accepted Start
- B  in  16  subtrahend; captured on accepted Start
- bin  in  1  borrow-in; captured on accepted Start
- D  out  16  difference; registered, held until next completion
- bout  out  1  borrow-out (unsigned A < B + bin)
- Overflow  out  1  signed two's-complement overflow
- Zero  out  1  D == 0
- Busy  out  1  high while an operation is in flight
- Done  out  1  one-cycle pulse when results update

## Operation
- States: IDLE, CALC, DONE.
- IDLE with Start=1 at an edge:
  - latch A, B into operand registers
  - carry register ← ~bin
  - nibble index ← 0
  - go to CALC
- CALC, each edge:
  - slice computes A_n + ~B_n + carry
  - the 4-bit result is written into accumulator bits [4n+3:4n]
  - carry ← slice carry-out
  - index increments
  - after index 3 is processed, go to DONE
- DONE, one cycle:
  - D ← accumulator
  - bout ← ~final carry
  - Overflow ← (A[15] ≠ B[15]) && (acc[15] ≠ A[15]), using the latched operands
  - Zero ← (acc == 0)
  - Done = 1
  - next state IDLE
- Busy = 1 in CALC and DONE, 0 in IDLE.
- Start is ignored in CALC and DONE; there is no queueing. Start is honoured again in the first IDLE cycle.
- A, B and bin may change freely after the accepted Start edge without affecting the result.
- D, bout, Overflow and Zero change only on the DONE update. Partial results are never visible.
- Arithmetic is modulo 2^16; the borrow out of nibble 3 is reported only through bout.

## Timing
- Reset (synchronous): state IDLE; index 0; carry 0; accumulator 0; D=0, bout=0, Overflow=0, Zero=0, Busy=0, Done=0.
- Reset mid-operation: aborts, returns to IDLE next edge, no Done pulse, outputs cleared to reset values.
- Reset and Start in the same cycle: Reset wins.
- Latency: Start accepted at edge t.
  - CALC occupies cycles t..t+3 (edges t+1..t+4 process nibbles 0..3).
  - DONE occupies cycle t+4; Done is high in cycle t+4 and registered outputs are valid from cycle t+5.
  - Minimum Start-to-Start spacing is 6 cycles (DONE returns to IDLE at edge t+5).
- Done is never high for two consecutive cycles.

## Structure
- Shared package `sub_pkg`:
  - state typedef enum {IDLE, CALC, DONE}
  - localparams W=16, NIBBLES=4, IDX_W=2
- Sub-module `subtract_slice_4`: combinational 4-bit slice.
  - Inputs: a[3:0], b[3:0], c_in.
  - Outputs: s[3:0] = a + ~b + c_in, c_out.
  - Built internally from four full-adder stages.
- Top level holds:
  - the FSM
  - operand, carry, index and accumulator registers
  - nibble muxing (the operand slice is selected by index)
  - the output register bank

## Test plan
- 0x1234 − 0x0234, bin=0 → D=0x1000, bout=0, Overflow=0, Zero=0; Done exactly 4 cycles after the Start edge cycle, single pulse.
- 0x0000 − 0x0001, bin=0 → D=0xFFFF, bout=1, Overflow=0 (borrow ripples through all four nibbles).
- 0x8000 − 0x0001 → D=0x7FFF, Overflow=1, bout=0; also 0x7FFF − 0xFFFF → D=0x8000, Overflow=1, bout=1.
- 0x5555 − 0x5554, bin=1 → D=0x0000, Zero=1, bout=0; operand inputs toggled randomly during CALC, and the result is unchanged.
- Start held high continuously → one operation per 6 cycles; extra Start pulses during Busy are ignored; D holds the previous result until the next Done.
- Reset asserted in the 2nd CALC cycle → Busy=0 and all outputs 0 on the next cycle, no Done; the following Start (0x0010 − 0x0001) → D=0x000F.
